// File: rtl/vp_pattern_gen.sv
// vp_pattern_gen
// Video timing and test-pattern source. It produces an IMG_HDISP x IMG_VDISP
// raster with blanking on the same vs/de/RGB888 stream the filter stage
// consumes, so it can stand in for the camera during bring-up.
//
// Optional build macro: PATTERN_SCROLL_EN
//   defined   : grid and gradient use x = h_cnt + frame count and scroll left
//               one pixel per frame
//   undefined : x = h_cnt, every pattern is static and no adder is built
module vp_pattern_gen #(
   parameter int IMG_HDISP = 1280,
   parameter int IMG_VDISP = 720,
   parameter int H_BLANK   = 370,
   parameter int V_BLANK   = 30,
   parameter int V_FP      = 4,
   parameter int V_SYNC    = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [23:0] solid_rgb,
   output logic        post_vs,
   output logic        post_de,
   output logic [23:0] post_data,
   output logic [7:0]  frame_cnt
);

   localparam int H_TOTAL = IMG_HDISP + H_BLANK;
   localparam int V_TOTAL = IMG_VDISP + V_BLANK;
   localparam int BAR_W   = IMG_HDISP / 8;
   localparam int BPW     = $clog2(BAR_W + 1);

   localparam logic [11:0]    H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0]    V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0]    H_ACT    = 12'(IMG_HDISP);
   localparam logic [11:0]    V_ACT    = 12'(IMG_VDISP);
   localparam logic [11:0]    VS_START = 12'(IMG_VDISP + V_FP);
   localparam logic [11:0]    VS_END   = 12'(IMG_VDISP + V_FP + V_SYNC);
   localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

   localparam logic [1:0] MODE_BARS  = 2'b00;
   localparam logic [1:0] MODE_GRID  = 2'b01;
   localparam logic [1:0] MODE_GRAD  = 2'b10;
   localparam logic [1:0] MODE_SOLID = 2'b11;

   logic [11:0]    h_cnt;
   logic [11:0]    v_cnt;
   logic [BPW-1:0] bar_pix;
   logic [2:0]     bar_idx;
   logic [1:0]     mode_sh;
   logic [23:0]    solid_sh;
   logic [7:0]     frame_int;

   logic           h_wrap;
   logic           v_wrap;
   logic           frame_start;
   logic [1:0]     mode_cur;
   logic [23:0]    solid_cur;
   logic [7:0]     x_lo;
   logic           active;
   logic           vs_zone;
   logic [23:0]    bar_rgb;
   logic [23:0]    pix;

   assign h_wrap      = (h_cnt == H_LAST);
   assign v_wrap      = (v_cnt == V_LAST);
   assign frame_start = (h_cnt == 12'd0) && (v_cnt == 12'd0);

   // The pixel at (0,0) must already use the freshly latched settings, so
   // the live inputs are used directly on that one cycle.
   assign mode_cur  = frame_start ? mode      : mode_sh;
   assign solid_cur = frame_start ? solid_rgb : solid_sh;

   assign active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign vs_zone = (v_cnt >= VS_START) && (v_cnt < VS_END);

   // Only the low byte of x feeds any pattern, so the sum is kept 8 bits wide.
`ifdef PATTERN_SCROLL_EN
   assign x_lo = h_cnt[7:0] + frame_int;
`else
   assign x_lo = h_cnt[7:0];
`endif

   // Raster counters: held at the origin while disabled or in reset.
   always_ff @(posedge clk) begin
      if (!rst_n || !en) begin
         h_cnt <= 12'd0;
         v_cnt <= 12'd0;
      end else if (h_wrap) begin
         h_cnt <= 12'd0;
         v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
      end else begin
         h_cnt <= h_cnt + 12'd1;
      end
   end

   // Bar position tracked incrementally alongside h_cnt so no divider is needed.
   always_ff @(posedge clk) begin
      if (!rst_n || !en || h_wrap) begin
         bar_pix <= '0;
         bar_idx <= 3'd0;
      end else if (bar_pix == BAR_LAST) begin
         bar_pix <= '0;
         bar_idx <= bar_idx + 3'd1;
      end else begin
         bar_pix <= bar_pix + BPW'(1);
      end
   end

   // Mode and solid colour shadows only change at the frame origin.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_sh  <= MODE_BARS;
         solid_sh <= 24'h000000;
      end else if (frame_start) begin
         mode_sh  <= mode;
         solid_sh <= solid_rgb;
      end
   end

   // Internal frame count steps as the counters wrap back to the origin.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_int <= 8'd0;
      end else if (en && h_wrap && v_wrap) begin
         frame_int <= frame_int + 8'd1;
      end
   end

   // Colour bar lookup, brightest to darkest.
   always_comb begin
      bar_rgb = 24'h000000;
      case (bar_idx)
         3'd0:    bar_rgb = 24'hFFFFFF;
         3'd1:    bar_rgb = 24'hFFFF00;
         3'd2:    bar_rgb = 24'h00FFFF;
         3'd3:    bar_rgb = 24'h00FF00;
         3'd4:    bar_rgb = 24'hFF00FF;
         3'd5:    bar_rgb = 24'hFF0000;
         3'd6:    bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
   end

   // Pattern selection for the current counter position.
   always_comb begin
      pix = 24'h000000;
      case (mode_cur)
         MODE_BARS: pix = bar_rgb;
         MODE_GRID: pix = ((x_lo[4:0] == 5'd0) || (v_cnt[4:0] == 5'd0)) ?
                          24'hFFFFFF : 24'h000000;
         MODE_GRAD: pix = {x_lo, v_cnt[7:0], x_lo ^ v_cnt[7:0]};
         default:   pix = solid_cur;
      endcase
   end

   // Registered stream outputs, one cycle behind the counters.
   always_ff @(posedge clk) begin
      if (!rst_n || !en) begin
         post_de   <= 1'b0;
         post_vs   <= 1'b0;
         post_data <= 24'h000000;
      end else begin
         post_de   <= active;
         post_vs   <= vs_zone;
         post_data <= active ? pix : 24'h000000;
      end
   end

   // Published frame count lines up with pixel (0,0) of the new frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= 8'd0;
      end else begin
         frame_cnt <= frame_int;
      end
   end

endmodule

// File: tb/tb_vp_pattern_gen.sv
// tb_vp_pattern_gen
// Directed bench for vp_pattern_gen on a 16x4 raster (20x10 total). Expected
// active pixels are queued before each frame; a monitor pops one per post_de
// cycle. Timing and spot values are checked from the stimulus process.
`timescale 1ns/1ps
module tb_vp_pattern_gen;

   localparam int HD    = 16;
   localparam int VD    = 4;
   localparam int HB    = 4;
   localparam int VB    = 6;
   localparam int VFP   = 1;
   localparam int VSY   = 2;
   localparam int HT    = HD + HB;
   localparam int VT    = VD + VB;
   localparam int FRAME = HT * VT;

`ifdef PATTERN_SCROLL_EN
   localparam int SCROLL = 1;
`else
   localparam int SCROLL = 0;
`endif

   localparam logic [1:0] P_BARS  = 2'b00;
   localparam logic [1:0] P_GRID  = 2'b01;
   localparam logic [1:0] P_GRAD  = 2'b10;
   localparam logic [1:0] P_SOLID = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [1:0]  mode;
   logic [23:0] solid_rgb;
   logic        post_vs;
   logic        post_de;
   logic [23:0] post_data;
   logic [7:0]  frame_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [23:0] data;
      logic [7:0]  fc;
   } exp_t;

   exp_t sb[$];

   vp_pattern_gen #(
      .IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB),
      .V_BLANK(VB), .V_FP(VFP), .V_SYNC(VSY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
      .post_vs(post_vs), .post_de(post_de), .post_data(post_data),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Expected colour of active pixel (h,v) for a given pattern and frame count.
   function automatic logic [23:0] expPixel(input logic [1:0] pat, input int h,
                                            input int v, input logic [7:0] fc,
                                            input logic [23:0] solid);
      int xs;
      logic [7:0] xb;
      logic [7:0] vb;
      xs = h + SCROLL * int'(fc);
      xb = 8'(xs);
      vb = 8'(v);
      case (pat)
         P_BARS: begin
            case (h / (HD / 8))
               0:       return 24'hFFFFFF;
               1:       return 24'hFFFF00;
               2:       return 24'h00FFFF;
               3:       return 24'h00FF00;
               4:       return 24'hFF00FF;
               5:       return 24'hFF0000;
               6:       return 24'h0000FF;
               default: return 24'h000000;
            endcase
         end
         P_GRID:  return ((xb[4:0] == 5'd0) || (vb[4:0] == 5'd0)) ? 24'hFFFFFF : 24'h000000;
         P_GRAD:  return {xb, vb, xb ^ vb};
         default: return solid;
      endcase
   endfunction

   // Queue the first 'count' active pixels of a frame in raster order.
   task automatic pushPixels(input logic [1:0] pat, input logic [7:0] fc,
                             input int count, input logic [23:0] solid);
      exp_t e;
      for (int i = 0; i < count; i++) begin
         e.data = expPixel(pat, i % HD, i / HD, fc, solid);
         e.fc   = fc;
         sb.push_back(e);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                                input logic [23:0] s);
      rst_n     = r;
      en        = e;
      mode      = m;
      solid_rgb = s;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic de, input logic vs,
                              input logic [23:0] data, input logic [7:0] fc);
      checks++;
      if ({post_de, post_vs, post_data, frame_cnt} !== {de, vs, data, fc}) begin
         errors++;
         $display("[TB] FAIL %s: got de=%b vs=%b data=%h fc=%0d, expected de=%b vs=%b data=%h fc=%0d",
                  name, post_de, post_vs, post_data, frame_cnt, de, vs, data, fc);
      end
   endtask

   task automatic checkInt(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: every post_de cycle consumes one expected pixel; idle cycles must be black.
   exp_t mon_e;
   int   mon_idx = 0;
   always @(posedge clk) begin
      #1;
      if (post_de) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_pixel: got data=%h with empty scoreboard, expected post_de=0", post_data);
         end else begin
            mon_e = sb.pop_front();
            if (post_data !== mon_e.data) begin
               errors++;
               $display("[TB] FAIL pixel_data #%0d: got %h, expected %h", mon_idx, post_data, mon_e.data);
            end
            checks++;
            if (frame_cnt !== mon_e.fc) begin
               errors++;
               $display("[TB] FAIL pixel_frame_cnt #%0d: got %0d, expected %0d", mon_idx, frame_cnt, mon_e.fc);
            end
            mon_idx++;
         end
      end else begin
         checks++;
         if (post_data !== 24'h000000) begin
            errors++;
            $display("[TB] FAIL blank_data: got %h, expected 000000", post_data);
         end
      end
      if (post_vs) begin
         checks++;
         if (post_de) begin
            errors++;
            $display("[TB] FAIL vs_de_overlap: got post_de=1 during post_vs, expected 0");
         end
      end
   end

   // Bound the whole run in case the design stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenario sequence.
   initial begin
      int de_line[VT];
      int vs_first;
      int vs_cnt;

      applyStimulus(1'b0, 1'b0, P_BARS, 24'h000000);
      repeat (3) stepCycle();
      checkOutput("reset_state", 1'b0, 1'b0, 24'h000000, 8'd0);
      applyStimulus(1'b1, 1'b0, P_BARS, 24'h000000);
      stepCycle();
      checkOutput("idle_en_low", 1'b0, 1'b0, 24'h000000, 8'd0);

      // Frame 0: colour bars plus line/frame timing.
      $display("[TB] frame 0: colour bars and timing");
      for (int i = 0; i < VT; i++) de_line[i] = 0;
      vs_first = -1;
      vs_cnt   = 0;
      pushPixels(P_BARS, 8'd0, HD * VD, 24'h0);
      applyStimulus(1'b1, 1'b1, P_BARS, 24'h000000);
      for (int k = 0; k < FRAME; k++) begin
         stepCycle();
         if (post_de) de_line[k / HT]++;
         if (post_vs) begin
            if (vs_first < 0) vs_first = k;
            vs_cnt++;
         end
         if (k == 0)   checkOutput("first_pixel_bar0", 1'b1, 1'b0, 24'hFFFFFF, 8'd0);
         if (k == 2)   checkOutput("bar1_start", 1'b1, 1'b0, 24'hFFFF00, 8'd0);
         if (k == 15)  checkOutput("bar7_last", 1'b1, 1'b0, 24'h000000, 8'd0);
         if (k == 16)  checkOutput("hblank_start", 1'b0, 1'b0, 24'h000000, 8'd0);
         if (k == 199) checkOutput("frame_tail", 1'b0, 1'b0, 24'h000000, 8'd0);
         if (k == 10)  applyStimulus(1'b1, 1'b1, P_GRAD, 24'h000000);
      end
      for (int v = 0; v < VT; v++)
         checkInt($sformatf("de_per_line_v%0d", v), de_line[v], (v < VD) ? HD : 0);
      checkInt("vs_first_cycle", vs_first, 100);
      checkInt("vs_width_cycles", vs_cnt, 40);

      // Frame 1: gradient, frame count 1.
      $display("[TB] frame 1: gradient");
      pushPixels(P_GRAD, 8'd1, HD * VD, 24'h0);
      for (int k = 0; k < FRAME; k++) begin
         stepCycle();
         if (k == 0)  checkOutput("period_restart", 1'b1, 1'b0,
                                  (SCROLL != 0) ? 24'h010001 : 24'h000000, 8'd1);
         if (k == 65) checkOutput("grad_x5_y3", 1'b1, 1'b0,
                                  (SCROLL != 0) ? 24'h060305 : 24'h050306, 8'd1);
         if (k == 10) applyStimulus(1'b1, 1'b1, P_SOLID, 24'h123456);
      end

      // Frame 2: solid, with a mode change part way that must not take hold.
      $display("[TB] frame 2: solid with mid-frame mode change");
      pushPixels(P_SOLID, 8'd2, HD * VD, 24'h123456);
      for (int k = 0; k < FRAME; k++) begin
         stepCycle();
         if (k == 40) applyStimulus(1'b1, 1'b1, P_GRID, 24'h123456);
         if (k == 45) checkOutput("solid_holds_after_change", 1'b1, 1'b0, 24'h123456, 8'd2);
      end

      // Frame 3: grid picks up the new mode.
      $display("[TB] frame 3: grid");
      pushPixels(P_GRID, 8'd3, HD * VD, 24'h0);
      for (int k = 0; k < FRAME; k++) begin
         stepCycle();
         if (k == 0)  checkOutput("grid_origin", 1'b1, 1'b0, 24'hFFFFFF, 8'd3);
         if (k == 21) checkOutput("grid_x1_y1", 1'b1, 1'b0, 24'h000000, 8'd3);
      end

      // Frame 4: aborted by en after pixel (7,1), then restarted.
      $display("[TB] frame 4: enable drop and restart");
      pushPixels(P_GRID, 8'd4, HD + 8, 24'h0);
      for (int k = 0; k < 28; k++) stepCycle();
      applyStimulus(1'b1, 1'b0, P_GRID, 24'h123456);
      for (int g = 0; g < 10; g++) begin
         stepCycle();
         checkOutput($sformatf("en_gap_%0d", g), 1'b0, 1'b0, 24'h000000, 8'd4);
      end
      pushPixels(P_GRID, 8'd4, HD * VD, 24'h0);
      applyStimulus(1'b1, 1'b1, P_GRID, 24'h123456);
      for (int k = 0; k < FRAME; k++) begin
         stepCycle();
         if (k == 0) checkOutput("restart_origin", 1'b1, 1'b0, 24'hFFFFFF, 8'd4);
      end

      // Next frame is cut short by a one-cycle reset.
      $display("[TB] reset mid-frame");
      pushPixels(P_GRID, 8'd5, 11, 24'h0);
      for (int k = 0; k < 11; k++) begin
         stepCycle();
         if (k == 0) checkOutput("frame_cnt_5", 1'b1, 1'b0, 24'hFFFFFF, 8'd5);
      end
      applyStimulus(1'b0, 1'b1, P_BARS, 24'h000000);
      stepCycle();
      checkOutput("reset_mid_frame", 1'b0, 1'b0, 24'h000000, 8'd0);
      pushPixels(P_BARS, 8'd0, HD * VD, 24'h0);
      applyStimulus(1'b1, 1'b1, P_BARS, 24'h000000);
      vs_cnt = 0;
      for (int k = 0; k < FRAME; k++) begin
         stepCycle();
         if (post_vs) vs_cnt++;
         if (k == 0) checkOutput("post_reset_bar0", 1'b1, 1'b0, 24'hFFFFFF, 8'd0);
         if (k == 5) checkOutput("post_reset_bar2", 1'b1, 1'b0, 24'h00FFFF, 8'd0);
      end
      checkInt("post_reset_vs_width", vs_cnt, 40);
      applyStimulus(1'b1, 1'b0, P_BARS, 24'h000000);
      stepCycle();
      checkOutput("frame_cnt_after_clean_frame", 1'b0, 1'b0, 24'h000000, 8'd1);
      checkInt("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
